// File: rtl/instr_register_pkg.sv
// instr_register_pkg: shared types for the instruction register and its reader.
//   opcode_t       - ALU opcode (4 bits; encodings above POW are undefined)
//   operand_t      - signed 32-bit operand
//   operand_res    - signed 64-bit result
//   address_t      - register entry index (NUM_ENTRIES deep)
//   instruction_t  - stored entry {opc, op_a, op_b, rezultat}
//   reader_state_t - instr_reader sequencer states
package instr_register_pkg;

  localparam int unsigned NUM_ENTRIES = 32;
  localparam int unsigned ADDR_W      = 5;
  localparam int unsigned OPERAND_W   = 32;
  localparam int unsigned RES_W       = 64;
  localparam int unsigned COUNT_W     = 6;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7,
    POW   = 4'd8
  } opcode_t;

  typedef logic signed [OPERAND_W-1:0] operand_t;
  typedef logic signed [RES_W-1:0]     operand_res;
  typedef logic [ADDR_W-1:0]           address_t;

  typedef struct packed {
    opcode_t    opc;
    operand_t   op_a;
    operand_t   op_b;
    operand_res rezultat;
  } instruction_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CHECK   = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } reader_state_t;

endpackage

// File: rtl/instr_result_model.sv
// instr_result_model: combinational reference ALU for stored instructions.
//   opc, op_a, op_b - instruction fields
//   res_c           - expected signed 64-bit result (operands sign-extended)
// DIV/MOD truncate toward zero; a zero divisor, ZERO and undefined opcodes give 0.
module instr_result_model
  import instr_register_pkg::*;
(
  input  opcode_t    opc,
  input  operand_t   op_a,
  input  operand_t   op_b,
  output operand_res res_c
);

  operand_res a_ext;
  operand_res b_ext;

  assign a_ext = RES_W'(op_a);
  assign b_ext = RES_W'(op_b);

  // Result select
  always_comb begin
    res_c = '0;
    case (opc)
      PASSA: res_c = a_ext;
      PASSB: res_c = b_ext;
      ADD:   res_c = a_ext + b_ext;
      SUB:   res_c = a_ext - b_ext;
      MULT:  res_c = a_ext * b_ext;
      POW:   res_c = a_ext * a_ext;
      DIV:   if (b_ext != '0) res_c = a_ext / b_ext;
      MOD:   if (b_ext != '0) res_c = a_ext % b_ext;
      default: res_c = '0;
    endcase
  end

endmodule

// File: rtl/instr_reader.sv
// instr_reader: read-side sequencer for the instruction register.
// Walks a wrapping range of entries, captures each word, optionally re-checks
// its stored result, and hands it downstream over valid/ready.
//   clk, reset_n          - clock, async active-low reset
//   start, first_ptr      - scan request (IDLE only) and first entry
//   count                 - entries to read, clamped to NUM_ENTRIES
//   read_pointer          - address to the register
//   instruction_word      - combinational read data
//   out_valid/out_ready   - downstream handshake; out_word, out_ok payload
//   busy, done, err_count - status; done is a one-cycle end-of-scan pulse
// Build option: INSTR_READER_CHECK_EN compiles in the CHECK state and result
// model; without it FETCH goes straight to PRESENT, out_ok=1, err_count=0.
module instr_reader
  import instr_register_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  address_t           first_ptr,
  input  logic [COUNT_W-1:0] count,
  output address_t           read_pointer,
  input  instruction_t       instruction_word,
  output logic               out_valid,
  input  logic               out_ready,
  output instruction_t       out_word,
  output logic               out_ok,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] err_count
);

  reader_state_t      state_q, state_d;
  address_t           ptr_q, ptr_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  instruction_t       word_q, word_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [COUNT_W-1:0] count_clamped_c;

  assign count_clamped_c = (count > COUNT_W'(NUM_ENTRIES)) ? COUNT_W'(NUM_ENTRIES) : count;

`ifdef INSTR_READER_CHECK_EN
  logic               ok_q, ok_d;
  logic [COUNT_W-1:0] err_q, err_d;
  operand_res         expected_c;
  logic               mismatch_c;

  instr_result_model u_model (
    .opc   (word_q.opc),
    .op_a  (word_q.op_a),
    .op_b  (word_q.op_b),
    .res_c (expected_c)
  );

  assign mismatch_c = (expected_c != word_q.rezultat);
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    word_d      = word_q;
`ifdef INSTR_READER_CHECK_EN
    ok_d        = ok_q;
    err_d       = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d       = first_ptr;
          remaining_d = count_clamped_c;
`ifdef INSTR_READER_CHECK_EN
          err_d       = '0;
`endif
          state_d     = (count_clamped_c == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        word_d = instruction_word;
`ifdef INSTR_READER_CHECK_EN
        state_d = CHECK;
`else
        state_d = PRESENT;
`endif
      end
`ifdef INSTR_READER_CHECK_EN
      CHECK: begin
        ok_d = !mismatch_c;
        // err_count saturates at all-ones
        if (mismatch_c && (err_q != '1)) err_d = err_q + COUNT_W'(1);
        state_d = PRESENT;
      end
`endif
      PRESENT: begin
        if (out_ready) begin
          if (remaining_q == COUNT_W'(1)) begin
            state_d = DONE;
          end else begin
            remaining_d = remaining_q - COUNT_W'(1);
            ptr_d       = (ptr_q == address_t'(NUM_ENTRIES - 1)) ? '0 : ptr_q + address_t'(1);
            state_d     = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == PRESENT);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef INSTR_READER_CHECK_EN
      ok_q        <= 1'b0;
      err_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef INSTR_READER_CHECK_EN
      ok_q        <= ok_d;
      err_q       <= err_d;
`endif
    end
  end

  assign read_pointer = ptr_q;
  assign out_valid    = valid_q;
  assign out_word     = word_q;
  assign busy         = busy_q;
  assign done         = done_q;
`ifdef INSTR_READER_CHECK_EN
  assign out_ok       = ok_q;
  assign err_count    = err_q;
`else
  assign out_ok       = 1'b1;
  assign err_count    = '0;
`endif

endmodule

// File: tb/tb_instr_reader.sv
// tb_instr_reader: directed bench for instr_reader with a queue scoreboard.
// A behavioural register array answers read_pointer combinationally.
module tb_instr_reader;
  import instr_register_pkg::*;

`ifdef INSTR_READER_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
  localparam int PER      = 3;
`else
  localparam bit CHECK_EN = 1'b0;
  localparam int PER      = 2;
`endif

  typedef struct {
    instruction_t word;
    logic         ok;
    address_t     ptr;
  } exp_t;

  logic               clk;
  logic               reset_n;
  logic               start;
  address_t           first_ptr;
  logic [COUNT_W-1:0] count;
  address_t           read_pointer;
  instruction_t       instruction_word;
  logic               out_valid;
  logic               out_ready;
  instruction_t       out_word;
  logic               out_ok;
  logic               busy;
  logic               done;
  logic [COUNT_W-1:0] err_count;

  opcode_t    m_opc;
  operand_t   m_a;
  operand_t   m_b;
  operand_res m_res;

  instruction_t mem [NUM_ENTRIES];
  logic         exp_ok [NUM_ENTRIES];
  exp_t         sb_q [$];
  int           n_checks;
  int           n_fail;

  instr_reader dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .first_ptr        (first_ptr),
    .count            (count),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_word         (out_word),
    .out_ok           (out_ok),
    .busy             (busy),
    .done             (done),
    .err_count        (err_count)
  );

  instr_result_model u_ref (
    .opc   (m_opc),
    .op_a  (m_a),
    .op_b  (m_b),
    .res_c (m_res)
  );

  assign instruction_word = mem[read_pointer];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic instruction_t mk(input opcode_t o, input int a, input int b, input longint r);
    instruction_t w;
    w.opc      = o;
    w.op_a     = a;
    w.op_b     = b;
    w.rezultat = r;
    return w;
  endfunction

  task automatic mcheck(input string tag, input opcode_t o, input int a, input int b, input longint r);
    m_opc = o;
    m_a   = a;
    m_b   = b;
    #1;
    check(tag, m_res, r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_ptr"}, read_pointer, 5'd0);
    check({tag, "_word"}, out_word, '0);
    check({tag, "_ok"}, out_ok, CHECK_EN ? 1'b0 : 1'b1);
    check({tag, "_err"}, err_count, 6'd0);
  endtask

  // One scan: push expectations, pulse start, then consume outputs until done.
  task automatic run_scan(input int first, input int cnt, input int stall, input string tag);
    int n, s, first_valid, last_valid, done_at, seen, exp_err, stall_left, idx;
    instruction_t held;
    exp_t e;
    n = (cnt > NUM_ENTRIES) ? NUM_ENTRIES : cnt;
    exp_err = 0;
    for (int i = 0; i < n; i++) begin
      idx = (first + i) % NUM_ENTRIES;
      e.word = mem[idx];
      e.ok   = CHECK_EN ? exp_ok[idx] : 1'b1;
      e.ptr  = address_t'(idx);
      sb_q.push_back(e);
      if (!exp_ok[idx]) exp_err++;
    end
    if (!CHECK_EN) exp_err = 0;

    first_ptr = address_t'(first);
    count     = COUNT_W'(cnt);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1'b1);

    first_valid = -1;
    last_valid  = -1;
    done_at     = -1;
    seen        = 0;
    stall_left  = stall;
    held        = '0;
    s           = 0;
    while (s < 400 && done_at < 0) begin
      if (done) begin
        done_at = s;
      end else if (out_valid) begin
        if (first_valid < 0) begin
          first_valid = s;
          held        = out_word;
        end
        if (stall_left > 0) begin
          out_ready = 1'b0;
          check({tag, "_stall_word_stable"}, out_word, held);
          // a start pulse while busy must be ignored
          if (stall_left == 3) begin
            start     = 1'b1;
            first_ptr = address_t'(20);
            count     = COUNT_W'(2);
          end else begin
            start = 1'b0;
          end
          stall_left--;
        end else begin
          start     = 1'b0;
          out_ready = 1'b1;
          if (last_valid >= 0 && stall == 0) check({tag, "_spacing"}, s - last_valid, PER);
          if (sb_q.size() == 0) begin
            check({tag, "_extra_word"}, 1'b1, 1'b0);
          end else begin
            e = sb_q.pop_front();
            check({tag, "_word"}, out_word, e.word);
            check({tag, "_ok"}, out_ok, e.ok);
            check({tag, "_ptr"}, read_pointer, e.ptr);
          end
          seen++;
          last_valid = s;
        end
      end
      tick();
      s++;
    end
    out_ready = 1'b1;
    start     = 1'b0;

    if (done_at < 0) begin
      check({tag, "_timeout"}, 1'b1, 1'b0);
    end else begin
      if (n == 0) check({tag, "_done_at"}, done_at, 0);
      else begin
        check({tag, "_first_valid"}, first_valid, PER - 1);
        check({tag, "_done_after_last"}, done_at, last_valid + 1);
      end
      check({tag, "_words_seen"}, seen, n);
      check({tag, "_err_at_done"}, err_count, COUNT_W'(exp_err));
      check({tag, "_sb_empty"}, sb_q.size(), 0);
      tick();
      check({tag, "_done_one_cycle"}, done, 1'b0);
      check({tag, "_idle_busy"}, busy, 1'b0);
      check({tag, "_err_hold"}, err_count, COUNT_W'(exp_err));
    end
    sb_q.delete();
  endtask

  initial begin
    int s;
    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    start     = 1'b0;
    first_ptr = '0;
    count     = '0;
    out_ready = 1'b1;

    for (int i = 0; i < NUM_ENTRIES; i++) begin
      mem[i]    = mk(PASSA, i * 7 - 50, i, longint'(i * 7 - 50));
      exp_ok[i] = 1'b1;
    end
    mem[0]  = mk(ADD, 5, 3, 8);
    mem[1]  = mk(SUB, 2, 7, -5);
    mem[2]  = mk(MULT, -4, 6, -24);
    mem[3]  = mk(POW, 9, 0, 81);
    mem[4]  = mk(DIV, -7, 2, -3);
    mem[5]  = mk(DIV, 7, 0, 0);
    mem[6]  = mk(ADD, 1, 1, 3);
    exp_ok[6] = 1'b0;
    mem[30] = mk(PASSB, 4, -11, 11);
    exp_ok[30] = 1'b0;
    mem[31] = mk(MOD, -9, 4, -1);

    // Reference model against hand-computed results
    mcheck("model_add", ADD, 5, 3, 8);
    mcheck("model_sub", SUB, 2, 7, -5);
    mcheck("model_mult", MULT, -4, 6, -24);
    mcheck("model_mult_wide", MULT, 32'h7fffffff, 2, 64'h0000_0000_ffff_fffe);
    mcheck("model_pow", POW, 9, 0, 81);
    mcheck("model_div_trunc", DIV, -7, 2, -3);
    mcheck("model_mod_trunc", MOD, -7, 2, -1);
    mcheck("model_div_zero", DIV, 7, 0, 0);
    mcheck("model_mod_zero", MOD, 7, 0, 0);
    mcheck("model_passa", PASSA, -12, 99, -12);
    mcheck("model_passb", PASSB, -12, 99, 99);
    mcheck("model_zero", ZERO, 3, 4, 0);
    mcheck("model_undef", opcode_t'(4'd12), 3, 4, 0);

    tick();
    tick();
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_reset_outputs("post_reset");

    run_scan(0, 4, 0, "basic");
    run_scan(5, 2, 0, "mismatch");
    run_scan(30, 4, 0, "wrap");
    run_scan(0, 4, 5, "stall");
    run_scan(7, 0, 0, "count0");
    run_scan(10, 40, 0, "clamp");

    // Reset while an entry is being presented
    first_ptr = address_t'(0);
    count     = COUNT_W'(4);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    s = 0;
    while (s < 10 && !out_valid) begin
      tick();
      s++;
    end
    check("midreset_reached_present", out_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick();
    check_reset_outputs("midreset_held");
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    tick();
    check_reset_outputs("midreset_release");
    run_scan(1, 3, 0, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
